// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_pkg
//  Description : Shared types and constants for the PHY management blocks
//                (link monitor and PHY configuration sequencer).
//                Contents:
//                  link_mon_state_t - link monitor FSM encoding
//                  phy_speed_t      - PHY-specific status speed field
//                  register addresses and status bit positions
//                  rd_reg_sel()     - read index to register address decode
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    // Link monitor FSM encoding
    typedef enum logic [2:0] {
        LM_IDLE   = 3'd0,
        LM_TIMER  = 3'd1,
        LM_ISSUE  = 3'd2,
        LM_WAIT   = 3'd3,
        LM_UPDATE = 3'd4
    } link_mon_state_t;

    // Speed field of the PHY-specific status register; 11 is passed through
    typedef enum logic [1:0] {
        SPEED_10M   = 2'b00,
        SPEED_100M  = 2'b01,
        SPEED_1000M = 2'b10,
        SPEED_RSVD  = 2'b11
    } phy_speed_t;

    // Register addresses, also used by the configuration sequencer
    localparam logic [4:0] PHY_BMSR_ADDR = 5'h01;
    localparam logic [4:0] PHY_STAT_ADDR = 5'h11;

    // Status bit positions
    localparam int BMSR_LINK_BIT   = 2;
    localparam int STAT_SPEED_MSB  = 15;
    localparam int STAT_DUPLEX_BIT = 13;

    // Read index 0 and 1 both target BMSR (latched-low clear, then real
    // sample); index 2 targets the PHY-specific status register.
    function automatic logic [4:0] rd_reg_sel(input logic [1:0] ridx,
                                              input logic [4:0] bmsr_addr,
                                              input logic [4:0] stat_addr);
        return (ridx == 2'd2) ? stat_addr : bmsr_addr;
    endfunction

endpackage : phy_pkg
`default_nettype wire

// File: rtl/mdio_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_rd_seq
//  Description : Single MDIO read transaction handler: command strobe
//                generation gated by master busy, and ack timeout counting.
//  Ports       : clk, rst              - clock, async active-high reset
//                issue_i               - owner is in its issue phase
//                wait_i                - owner is waiting for the ack
//                ridx_i[1:0]           - read index selecting the register
//                mdio_busy_i/ack_i     - master handshake inputs
//                mdio_cmd_*_o          - command port to mdio_master
//                ack_o                 - ack received while waiting
//                timeout_o             - ack wait expired (ack has priority)
//  Revision    : 1.0 - initial release
// ============================================================================
module mdio_rd_seq
    import phy_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter logic [4:0]  BMSR_REG    = PHY_BMSR_ADDR,
    parameter logic [4:0]  STAT_REG    = PHY_STAT_ADDR,
    parameter int unsigned ACK_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_i,
    input  logic        wait_i,
    input  logic [1:0]  ridx_i,
    input  logic        mdio_busy_i,
    input  logic        mdio_ack_i,
    output logic        mdio_cmd_valid_o,
    output logic        mdio_cmd_read_o,
    output logic [4:0]  mdio_cmd_phy_o,
    output logic [4:0]  mdio_cmd_reg_o,
    output logic [15:0] mdio_cmd_wdata_o,
    output logic        ack_o,
    output logic        timeout_o
);

    localparam int          CW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_valid;

    // Combinational strobe so a busy assertion in the same cycle always
    // suppresses the command.
    assign w_valid          = issue_i & ~mdio_busy_i;
    assign mdio_cmd_valid_o = w_valid;
    assign mdio_cmd_read_o  = w_valid;
    assign mdio_cmd_phy_o   = w_valid ? PHY_ADDR : 5'h00;
    assign mdio_cmd_reg_o   = w_valid ? rd_reg_sel(ridx_i, BMSR_REG, STAT_REG) : 5'h00;
    assign mdio_cmd_wdata_o = 16'h0000;

    assign ack_o     = wait_i & mdio_ack_i;
    assign timeout_o = wait_i & ~mdio_ack_i & (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (w_valid) begin
            cnt_d = '0;
        end else if (wait_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : mdio_rd_seq
`default_nettype wire

// File: rtl/phy_link_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : phy_link_monitor
//  Description : Periodic PHY link-status poller. Each round reads BMSR
//                twice (latched-low clear, then real sample) and the
//                PHY-specific status register, then filters the link bit
//                and publishes link_up / speed / duplex.
//  Ports       : clk, rst              - clock, async active-high reset
//                enable                - polling allowed (MDIO port granted)
//                mdio_cmd_*            - command port to mdio_master
//                mdio_busy/ack/rdata   - mdio_master response
//                link_up, speed,
//                full_duplex           - filtered link status
//                link_change           - one-cycle pulse on link_up toggle
//                mdio_err              - sticky ack-timeout flag
//                poll_active           - a poll round is in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_link_monitor
    import phy_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 1_250_000,
    parameter logic [4:0]  PHY_ADDR    = 5'h01,
    parameter logic [4:0]  BMSR_REG    = PHY_BMSR_ADDR,
    parameter logic [4:0]  STAT_REG    = PHY_STAT_ADDR,
    parameter int unsigned ACK_TIMEOUT = 4096,
    parameter int unsigned LINK_FILTER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        mdio_cmd_valid,
    output logic        mdio_cmd_read,
    output logic [4:0]  mdio_cmd_phy,
    output logic [4:0]  mdio_cmd_reg,
    output logic [15:0] mdio_cmd_wdata,
    input  logic        mdio_busy,
    input  logic        mdio_ack,
    input  logic [15:0] mdio_rdata,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        link_change,
    output logic        mdio_err,
    output logic        poll_active
);

    localparam logic [2:0] S_IDLE   = LM_IDLE;
    localparam logic [2:0] S_TIMER  = LM_TIMER;
    localparam logic [2:0] S_ISSUE  = LM_ISSUE;
    localparam logic [2:0] S_WAIT   = LM_WAIT;
    localparam logic [2:0] S_UPDATE = LM_UPDATE;

    localparam int            TW         = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_CYCLES - 1);
    localparam logic [3:0]    FILT_LIM   = 4'(LINK_FILTER);

    logic [2:0]    state_q, state_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          first_q, first_d;
    logic          bmsr_link_q, bmsr_link_d;
    phy_speed_t    stat_speed_q, stat_speed_d;
    logic          stat_dup_q, stat_dup_d;
    logic          link_q, link_d;
    phy_speed_t    speed_q, speed_d;
    logic          dup_q, dup_d;
    logic          chg_q, chg_d;
    logic          err_q, err_d;
    logic [3:0]    filt_q, filt_d;
    logic          active_q, active_d;

    logic          w_issue;
    logic          w_wait;
    logic          w_ack;
    logic          w_timeout;
    logic          w_link_new;
    logic          w_unused_rdata;

    // Only a few status bits are kept; the rest of each read is dropped.
    assign w_unused_rdata = ^mdio_rdata;

    // The MDIO port is only ours while enable is high.
    assign w_issue = (state_q == S_ISSUE) & enable;
    assign w_wait  = (state_q == S_WAIT);

    mdio_rd_seq #(
        .PHY_ADDR    (PHY_ADDR),
        .BMSR_REG    (BMSR_REG),
        .STAT_REG    (STAT_REG),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_rd_seq (
        .clk              (clk),
        .rst              (rst),
        .issue_i          (w_issue),
        .wait_i           (w_wait),
        .ridx_i           (ridx_q),
        .mdio_busy_i      (mdio_busy),
        .mdio_ack_i       (mdio_ack),
        .mdio_cmd_valid_o (mdio_cmd_valid),
        .mdio_cmd_read_o  (mdio_cmd_read),
        .mdio_cmd_phy_o   (mdio_cmd_phy),
        .mdio_cmd_reg_o   (mdio_cmd_reg),
        .mdio_cmd_wdata_o (mdio_cmd_wdata),
        .ack_o            (w_ack),
        .timeout_o        (w_timeout)
    );

    always_comb begin
        state_d      = state_q;
        ridx_d       = ridx_q;
        timer_d      = timer_q;
        first_d      = first_q;
        bmsr_link_d  = bmsr_link_q;
        stat_speed_d = stat_speed_q;
        stat_dup_d   = stat_dup_q;
        link_d       = link_q;
        speed_d      = speed_q;
        dup_d        = dup_q;
        chg_d        = 1'b0;
        err_d        = err_q;
        filt_d       = filt_q;
        active_d     = active_q;
        w_link_new   = link_q;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    timer_d = '0;
                    first_d = 1'b1;
                    state_d = S_TIMER;
                end
            end

            S_TIMER: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (first_q || (timer_q == TIMER_LAST)) begin
                    // First entry after enable skips the poll interval.
                    first_d = 1'b0;
                    ridx_d  = 2'd0;
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_ISSUE: begin
                if (!enable) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (!mdio_busy) begin
                    if (ridx_q == 2'd0) begin
                        active_d = 1'b1;
                    end
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (w_ack) begin
                    if (ridx_q == 2'd1) begin
                        bmsr_link_d = mdio_rdata[BMSR_LINK_BIT];
                    end
                    if (ridx_q == 2'd2) begin
                        stat_speed_d = phy_speed_t'(mdio_rdata[STAT_SPEED_MSB -: 2]);
                        stat_dup_d   = mdio_rdata[STAT_DUPLEX_BIT];
                    end
                    if (!enable) begin
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else if (ridx_q != 2'd2) begin
                        ridx_d  = ridx_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        active_d = 1'b0;
                        state_d  = S_UPDATE;
                    end
                end else if (w_timeout) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    timer_d  = '0;
                    state_d  = enable ? S_TIMER : S_IDLE;
                end
            end

            S_UPDATE: begin
                if (bmsr_link_q != link_q) begin
                    if ((filt_q + 4'd1) == FILT_LIM) begin
                        w_link_new = ~link_q;
                        chg_d      = 1'b1;
                        filt_d     = 4'd0;
                    end else begin
                        filt_d = filt_q + 4'd1;
                    end
                end else begin
                    filt_d = 4'd0;
                end
                link_d = w_link_new;
                if (w_link_new) begin
                    speed_d = stat_speed_q;
                    dup_d   = stat_dup_q;
                end else begin
                    speed_d = SPEED_10M;
                    dup_d   = 1'b0;
                end
                timer_d = '0;
                state_d = S_TIMER;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ridx_q       <= 2'd0;
            timer_q      <= '0;
            first_q      <= 1'b0;
            bmsr_link_q  <= 1'b0;
            stat_speed_q <= SPEED_10M;
            stat_dup_q   <= 1'b0;
            link_q       <= 1'b0;
            speed_q      <= SPEED_10M;
            dup_q        <= 1'b0;
            chg_q        <= 1'b0;
            err_q        <= 1'b0;
            filt_q       <= 4'd0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ridx_q       <= ridx_d;
            timer_q      <= timer_d;
            first_q      <= first_d;
            bmsr_link_q  <= bmsr_link_d;
            stat_speed_q <= stat_speed_d;
            stat_dup_q   <= stat_dup_d;
            link_q       <= link_d;
            speed_q      <= speed_d;
            dup_q        <= dup_d;
            chg_q        <= chg_d;
            err_q        <= err_d;
            filt_q       <= filt_d;
            active_q     <= active_d;
        end
    end

    assign link_up     = link_q;
    assign speed       = speed_q;
    assign full_duplex = dup_q;
    assign link_change = chg_q;
    assign mdio_err    = err_q;
    assign poll_active = active_q;

endmodule : phy_link_monitor
`default_nettype wire

// File: tb/tb_phy_link_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_link_monitor
//  Description : Scoreboard bench for phy_link_monitor with a simple
//                MDIO master / PHY model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_link_monitor;

    localparam int POLL = 64;
    localparam int TMO  = 32;

    typedef struct packed {
        logic       link;
        logic [1:0] spd;
        logic       dup;
    } evt_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        mdio_cmd_valid;
    logic        mdio_cmd_read;
    logic [4:0]  mdio_cmd_phy;
    logic [4:0]  mdio_cmd_reg;
    logic [15:0] mdio_cmd_wdata;
    logic        mdio_busy;
    logic        mdio_ack;
    logic [15:0] mdio_rdata;
    logic        link_up;
    logic [1:0]  speed;
    logic        full_duplex;
    logic        link_change;
    logic        mdio_err;
    logic        poll_active;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [4:0] exp_cmd[$];
    evt_t       exp_evt[$];

    // PHY model state
    logic [15:0] bmsr_val  = 16'h796D;
    logic [15:0] stat_val  = 16'hAC00;
    bit          noack     = 0;
    bit          force_busy = 0;
    bit          model_busy = 0;
    int          lat       = 0;
    logic [4:0]  model_reg = 5'h00;
    int          stat_acks = 0;

    // Monitor state
    int          cmd_count    = 0;
    int          last_cmd_cyc = 0;
    int          last_busy_cyc = 0;
    bit          chk_busy_fall = 0;
    logic [4:0]  mon_reg;
    evt_t        mon_evt;

    phy_link_monitor #(
        .POLL_CYCLES (POLL),
        .PHY_ADDR    (5'h01),
        .BMSR_REG    (5'h01),
        .STAT_REG    (5'h11),
        .ACK_TIMEOUT (TMO),
        .LINK_FILTER (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .mdio_cmd_valid (mdio_cmd_valid),
        .mdio_cmd_read  (mdio_cmd_read),
        .mdio_cmd_phy   (mdio_cmd_phy),
        .mdio_cmd_reg   (mdio_cmd_reg),
        .mdio_cmd_wdata (mdio_cmd_wdata),
        .mdio_busy      (mdio_busy),
        .mdio_ack       (mdio_ack),
        .mdio_rdata     (mdio_rdata),
        .link_up        (link_up),
        .speed          (speed),
        .full_duplex    (full_duplex),
        .link_change    (link_change),
        .mdio_err       (mdio_err),
        .poll_active    (poll_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // MDIO master + PHY model: ack four cycles after the command
    initial begin
        mdio_busy  = 1'b0;
        mdio_ack   = 1'b0;
        mdio_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mdio_cmd_valid && !model_busy) begin
                model_busy = 1;
                lat        = 3;
                model_reg  = mdio_cmd_reg;
            end
            @(posedge clk);
            #1;
            mdio_ack   = 1'b0;
            mdio_rdata = 16'h0000;
            if (model_busy) begin
                if (lat == 0) begin
                    model_busy = 0;
                    if (!noack) begin
                        mdio_ack   = 1'b1;
                        mdio_rdata = (model_reg == 5'h11) ? stat_val : bmsr_val;
                        if (model_reg == 5'h11) stat_acks++;
                    end
                end else begin
                    lat--;
                end
            end
            mdio_busy = model_busy | force_busy;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mdio_cmd_valid) begin
            last_cmd_cyc = cyc;
            cmd_count++;
            check("cmd_while_busy", 32'(mdio_busy), 32'd0);
            check("cmd_phy", 32'(mdio_cmd_phy), 32'h01);
            check("cmd_read", 32'(mdio_cmd_read), 32'd1);
            check("cmd_wdata", 32'(mdio_cmd_wdata), 32'h0);
            if (exp_cmd.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_cmd: got reg %0h, required no command (cycle %0d)", mdio_cmd_reg, cyc);
            end else begin
                mon_reg = exp_cmd.pop_front();
                check("cmd_reg", 32'(mdio_cmd_reg), 32'(mon_reg));
            end
            if (chk_busy_fall) begin
                check("cmd_after_busy_fall", 32'(cyc), 32'(last_busy_cyc + 1));
                chk_busy_fall = 0;
            end
        end
        if (mdio_busy) last_busy_cyc = cyc;
        if (link_change) begin
            if (exp_evt.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_link_change: got link_up=%0b, required no pulse (cycle %0d)", link_up, cyc);
            end else begin
                mon_evt = exp_evt.pop_front();
                check("evt", 32'({link_up, speed, full_duplex}), 32'(mon_evt));
            end
        end
    end

    task automatic push_round();
        exp_cmd.push_back(5'h01);
        exp_cmd.push_back(5'h01);
        exp_cmd.push_back(5'h11);
    endtask

    // Wait for the STAT ack of the current round, then for the UPDATE result
    task automatic run_round(input string nm);
        int start;
        bit done;
        start = stat_acks;
        done  = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (stat_acks != start) done = 1;
        end
        check({nm, "_done"}, 32'(done), 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_link(input string nm, input logic l, input logic [1:0] s, input logic d);
        check({nm, "_link"}, 32'({link_up, speed, full_duplex}), 32'({l, s, d}));
    endtask

    initial begin
        int  start;
        int  en_cyc;
        bit  done;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({mdio_cmd_valid, mdio_cmd_read, mdio_cmd_phy, mdio_cmd_reg, link_up,
                   speed, full_duplex, link_change, mdio_err, poll_active}), 32'd0);
        check("reset_wdata", 32'(mdio_cmd_wdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // Link comes up after two agreeing rounds
        bmsr_val = 16'h796D;
        stat_val = 16'hAC00;
        push_round();
        @(posedge clk); #1;
        enable = 1'b1;
        run_round("t1_r1");
        check_link("t1_r1", 1'b0, 2'b00, 1'b0);
        push_round();
        exp_evt.push_back('{link: 1'b1, spd: 2'b10, dup: 1'b1});
        run_round("t1_r2");
        check_link("t1_r2", 1'b1, 2'b10, 1'b1);

        // enable drops during the second BMSR read
        bmsr_val = 16'h7969;
        exp_cmd.push_back(5'h01);
        exp_cmd.push_back(5'h01);
        start = cmd_count;
        done  = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (cmd_count == start + 2) done = 1;
        end
        check("t5_second_bmsr", 32'(done), 32'd1);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check_link("t5_held", 1'b1, 2'b10, 1'b1);
        check("t5_poll_active", 32'(poll_active), 32'd0);
        check("t5_queue_empty", 32'(exp_cmd.size()), 32'd0);

        // Re-enable starts a round right away
        bmsr_val = 16'h796D;
        push_round();
        @(posedge clk); #1;
        enable = 1'b1;
        en_cyc = cyc;
        start  = cmd_count;
        for (int i = 0; i < 20 && cmd_count == start; i++) @(negedge clk);
        check("t5_restart_latency", 32'(last_cmd_cyc - en_cyc), 32'd2);
        run_round("t5_r");
        check_link("t5_r", 1'b1, 2'b10, 1'b1);

        // One-round glitch is filtered, then a real drop takes two rounds
        bmsr_val = 16'h7969;
        push_round();
        run_round("t2_glitch");
        check_link("t2_glitch", 1'b1, 2'b10, 1'b1);
        bmsr_val = 16'h796D;
        push_round();
        run_round("t2_back");
        check_link("t2_back", 1'b1, 2'b10, 1'b1);
        bmsr_val = 16'h7969;
        push_round();
        run_round("t2_d1");
        check_link("t2_d1", 1'b1, 2'b10, 1'b1);
        push_round();
        exp_evt.push_back('{link: 1'b0, spd: 2'b00, dup: 1'b0});
        run_round("t2_d2");
        check_link("t2_d2", 1'b0, 2'b00, 1'b0);

        // Master held busy across the ISSUE phase
        @(posedge clk); #2;
        force_busy = 1;
        push_round();
        repeat (500) @(posedge clk);
        #2;
        chk_busy_fall = 1;
        force_busy    = 0;
        run_round("t4_r");
        check("t4_busy_cmd_seen", 32'(chk_busy_fall), 32'd0);
        check("t4_err_clear", 32'(mdio_err), 32'd0);
        check_link("t4_r", 1'b0, 2'b00, 1'b0);

        // No ack: timeout sets the sticky error, next round still runs
        @(posedge clk); #2;
        noack = 1;
        exp_cmd.push_back(5'h01);
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (mdio_err) done = 1;
        end
        check("t3_err_set", 32'(done), 32'd1);
        check("t3_err_latency", 32'(cyc - last_cmd_cyc), 32'(TMO + 1));
        check_link("t3_after_tmo", 1'b0, 2'b00, 1'b0);
        @(posedge clk); #2;
        noack = 0;
        push_round();
        run_round("t3_next");
        check("t3_err_sticky", 32'(mdio_err), 32'd1);
        check_link("t3_next", 1'b0, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a wait
        exp_cmd.push_back(5'h01);
        start = cmd_count;
        for (int i = 0; i < 300 && cmd_count == start; i++) @(negedge clk);
        check("t6_cmd_seen", 32'(cmd_count - start), 32'd1);
        @(posedge clk); #3;
        check("t6_active_before", 32'(poll_active), 32'd1);
        rst    = 1'b1;
        enable = 1'b0;
        #1;
        check("t6_async_reset",
              32'({mdio_cmd_valid, link_up, speed, full_duplex, link_change, mdio_err, poll_active}),
              32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("t6_idle_no_cmd", 32'(cmd_count - start), 32'd1);
        push_round();
        @(posedge clk); #1;
        enable = 1'b1;
        run_round("t6_recover");
        check("t6_err_cleared", 32'(mdio_err), 32'd0);

        repeat (5) @(negedge clk);
        check("final_cmd_queue", 32'(exp_cmd.size()), 32'd0);
        check("final_evt_queue", 32'(exp_evt.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute runtime guard
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish before limit");
        $fatal(1, "runtime limit");
    end

endmodule : tb_phy_link_monitor
`default_nettype wire
